// File: rtl/hps_reset_sequencer.sv
// HPS warm/cold reset request sequencer: hold, ack handshake, cooldown lockout.
// Optional WAIT_ACK timeout is enabled by defining HPS_RST_SEQ_TIMEOUT_EN.
module hps_reset_sequencer #(
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 65535,
    parameter int unsigned COOLDOWN_CYCLES = 1024,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             warm_pulse,
    input  logic             cold_pulse,
    input  logic             hps_rst_ack,
    input  logic             clr_flags,
    output logic             warm_rst_req_n,
    output logic             cold_rst_req_n,
    output logic             busy,
    output logic             dropped,
    output logic             timeout_flag,
    output logic [CNT_W-1:0] seq_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ASSERT   = 3'd1,
        WAIT_ACK = 3'd2,
        WAIT_REL = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    // Counters are loaded with N-1 so a state held for N cycles exits when the count reads zero.
    localparam logic [15:0] HOLD_LOAD     = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LOAD  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] COOLDOWN_LOAD = 16'(COOLDOWN_CYCLES - 1);

`ifdef HPS_RST_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t           state_r;
    logic [15:0]      cnt_r;
    logic [1:0]       ack_sync_r;
    logic             ack_s;
    logic             warm_req_n_r;
    logic             cold_req_n_r;
    logic             busy_r;
    logic             dropped_r;
    logic [CNT_W-1:0] seq_cnt_r;
    logic             drop_set_s;
    logic             timeout_set_s;

    assign ack_s         = ack_sync_r[1];
    assign drop_set_s    = (warm_pulse | cold_pulse) & (state_r != IDLE);
    assign timeout_set_s = TIMEOUT_EN & (state_r == WAIT_ACK) & ~ack_s & (cnt_r == 16'd0);

    // Two-flop synchronizer for the asynchronous HPS acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sync_r <= 2'b00;
        end else begin
            ack_sync_r <= {ack_sync_r[0], hps_rst_ack};
        end
    end

    // Sticky dropped-request flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropped_r <= 1'b0;
        end else if (drop_set_s) begin
            dropped_r <= 1'b1;
        end else if (clr_flags) begin
            dropped_r <= 1'b0;
        end else begin
            dropped_r <= dropped_r;
        end
    end

`ifdef HPS_RST_SEQ_TIMEOUT_EN
    logic timeout_r;

    // Sticky acknowledge-timeout flag; a new timeout wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_r <= 1'b0;
        end else if (timeout_set_s) begin
            timeout_r <= 1'b1;
        end else if (clr_flags) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign timeout_flag = timeout_r;
`else
    assign timeout_flag = 1'b0;
`endif

    // Sequencer FSM with registered request, busy and completion-count outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 16'd0;
            warm_req_n_r <= 1'b1;
            cold_req_n_r <= 1'b1;
            busy_r       <= 1'b0;
            seq_cnt_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Cold takes priority so only one request line can ever be low.
                    if (cold_pulse) begin
                        state_r      <= ASSERT;
                        cnt_r        <= HOLD_LOAD;
                        cold_req_n_r <= 1'b0;
                        busy_r       <= 1'b1;
                    end else if (warm_pulse) begin
                        state_r      <= ASSERT;
                        cnt_r        <= HOLD_LOAD;
                        warm_req_n_r <= 1'b0;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ASSERT: begin
                    if (cnt_r == 16'd0) begin
                        state_r      <= WAIT_ACK;
                        cnt_r        <= TIMEOUT_LOAD;
                        warm_req_n_r <= 1'b1;
                        cold_req_n_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                WAIT_ACK: begin
                    if (ack_s) begin
                        state_r <= WAIT_REL;
                    end else if (timeout_set_s) begin
                        state_r <= COOLDOWN;
                        cnt_r   <= COOLDOWN_LOAD;
                    end else if (TIMEOUT_EN) begin
                        cnt_r <= cnt_r - 16'd1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                WAIT_REL: begin
                    if (!ack_s) begin
                        state_r <= COOLDOWN;
                        cnt_r   <= COOLDOWN_LOAD;
                        if (seq_cnt_r != {CNT_W{1'b1}}) begin
                            seq_cnt_r <= seq_cnt_r + CNT_W'(1);
                        end else begin
                            seq_cnt_r <= seq_cnt_r;
                        end
                    end else begin
                        state_r <= WAIT_REL;
                    end
                end
                COOLDOWN: begin
                    if (cnt_r == 16'd0) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= 16'd0;
                    warm_req_n_r <= 1'b1;
                    cold_req_n_r <= 1'b1;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign warm_rst_req_n = warm_req_n_r;
    assign cold_rst_req_n = cold_req_n_r;
    assign busy           = busy_r;
    assign dropped        = dropped_r;
    assign seq_cnt        = seq_cnt_r;

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Directed self-checking bench for hps_reset_sequencer (HOLD=4, TIMEOUT=20, COOLDOWN=8, CNT_W=2).
module tb_hps_reset_sequencer;

    localparam int unsigned HOLD = 4;
    localparam int unsigned TO   = 20;
    localparam int unsigned CD   = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       warm_pulse;
    logic       cold_pulse;
    logic       hps_rst_ack;
    logic       clr_flags;
    logic       warm_rst_req_n;
    logic       cold_rst_req_n;
    logic       busy;
    logic       dropped;
    logic       timeout_flag;
    logic [1:0] seq_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hps_reset_sequencer #(
        .HOLD_CYCLES     (HOLD),
        .TIMEOUT_CYCLES  (TO),
        .COOLDOWN_CYCLES (CD),
        .CNT_W           (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .warm_pulse     (warm_pulse),
        .cold_pulse     (cold_pulse),
        .hps_rst_ack    (hps_rst_ack),
        .clr_flags      (clr_flags),
        .warm_rst_req_n (warm_rst_req_n),
        .cold_rst_req_n (cold_rst_req_n),
        .busy           (busy),
        .dropped        (dropped),
        .timeout_flag   (timeout_flag),
        .seq_cnt        (seq_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete request sequence; edge E0 samples the pulse.
    task automatic run_seq(input bit cold, input bit both, input bit drop, input logic [1:0] exp_cnt);
        logic exp_w;
        logic exp_c;
        exp_w = cold ? 1'b1 : 1'b0;
        exp_c = cold ? 1'b0 : 1'b1;
        cold_pulse = cold;
        warm_pulse = !cold || both;
        tick();
        cold_pulse = 1'b0;
        warm_pulse = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            chk("hold_warm_req_n", warm_rst_req_n, exp_w);
            chk("hold_cold_req_n", cold_rst_req_n, exp_c);
            chk("hold_busy", busy, 1'b1);
            tick();
        end
        chk("release_warm_req_n", warm_rst_req_n, 1'b1);
        chk("release_cold_req_n", cold_rst_req_n, 1'b1);
        chk("wait_ack_busy", busy, 1'b1);
        hps_rst_ack = 1'b1;
        warm_pulse  = drop;
        tick();
        warm_pulse = 1'b0;
        if (drop) begin
            chk("drop_flag", dropped, 1'b1);
            chk("drop_no_warm_req", warm_rst_req_n, 1'b1);
            chk("drop_no_cold_req", cold_rst_req_n, 1'b1);
        end
        tick();
        tick();
        hps_rst_ack = 1'b0;
        repeat (3) tick();
        chk("seq_cnt", seq_cnt, exp_cnt);
        chk("cooldown_entry_busy", busy, 1'b1);
        repeat (CD - 1) tick();
        chk("cooldown_last_busy", busy, 1'b1);
        tick();
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        warm_pulse  = 1'b0;
        cold_pulse  = 1'b0;
        hps_rst_ack = 1'b0;
        clr_flags   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_warm_req_n", warm_rst_req_n, 1'b1);
        chk("rst_cold_req_n", cold_rst_req_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dropped", dropped, 1'b0);
        chk("rst_timeout", timeout_flag, 1'b0);
        chk("rst_seq_cnt", seq_cnt, 2'd0);
        rst = 1'b0;
        tick();

        // No acknowledge: WAIT_ACK entered at E4.
        warm_pulse = 1'b1;
        tick();
        warm_pulse = 1'b0;
        repeat (HOLD) tick();
        chk("to_wait_warm_req_n", warm_rst_req_n, 1'b1);
        repeat (TO - 1) tick();
        chk("to_early_flag", timeout_flag, 1'b0);
        chk("to_early_busy", busy, 1'b1);
        tick();
`ifdef HPS_RST_SEQ_TIMEOUT_EN
        chk("to_flag", timeout_flag, 1'b1);
        chk("to_seq_cnt", seq_cnt, 2'd0);
        chk("to_busy", busy, 1'b1);
        repeat (CD - 1) tick();
        chk("to_cooldown_busy", busy, 1'b1);
        tick();
        chk("to_idle_busy", busy, 1'b0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("to_clr_flag", timeout_flag, 1'b0);
`else
        chk("noto_flag", timeout_flag, 1'b0);
        chk("noto_busy", busy, 1'b1);
        repeat (10) tick();
        chk("noto_busy_later", busy, 1'b1);
        chk("noto_seq_cnt", seq_cnt, 2'd0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", busy, 1'b0);

        run_seq(1'b0, 1'b0, 1'b0, 2'd1);
        run_seq(1'b1, 1'b1, 1'b0, 2'd2);
        run_seq(1'b0, 1'b0, 1'b1, 2'd3);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("clr_dropped", dropped, 1'b0);
        run_seq(1'b1, 1'b0, 1'b0, 2'd3);
        run_seq(1'b0, 1'b0, 1'b0, 2'd3);

        // Drop and clear in the same cycle, then reset mid-ASSERT.
        warm_pulse = 1'b1;
        tick();
        warm_pulse = 1'b0;
        chk("midrst_warm_low", warm_rst_req_n, 1'b0);
        cold_pulse = 1'b1;
        clr_flags  = 1'b1;
        tick();
        cold_pulse = 1'b0;
        clr_flags  = 1'b0;
        chk("set_wins_dropped", dropped, 1'b1);
        chk("set_wins_cold_req_n", cold_rst_req_n, 1'b1);
        chk("set_wins_warm_low", warm_rst_req_n, 1'b0);
        rst = 1'b1;
        #1;
        chk("async_rst_warm_req_n", warm_rst_req_n, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_dropped", dropped, 1'b0);
        chk("async_rst_seq_cnt", seq_cnt, 2'd0);
        tick();
        rst = 1'b0;
        tick();
        run_seq(1'b0, 1'b0, 1'b0, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
